dec_entry: RTL

Decimal number entry block for the board-level number-systems design: the inverse direction of the binary-switch → hex/decimal display path. The user dials one BCD digit at a time on the switches and presses a push button to append it. The block accumulates the digits into a binary value (`value = value*10 + digit`) and flags overflow and illegal digits. Its binary output drives LEDR and can feed the existing hex/decimal display path for round-trip checking.

---
 rtl/num_syst_pkg.sv | 33 +++
 rtl/key_debounce.sv | 47 ++++
 rtl/dec_entry.sv | 90 +++++++++
 3 files changed

// File: rtl/num_syst_pkg.sv
// Shared types and constants for the number-systems board design:
// decimal entry FSM encoding, BCD limit and seven-segment glyphs.
package num_syst_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2,
        OVF   = 2'd3
    } entry_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Active-low segment patterns {g,f,e,d,c,b,a}, shared with the display decoder.
    localparam logic [6:0] SEG_0 = 7'b100_0000;
    localparam logic [6:0] SEG_1 = 7'b111_1001;
    localparam logic [6:0] SEG_2 = 7'b010_0100;
    localparam logic [6:0] SEG_3 = 7'b011_0000;
    localparam logic [6:0] SEG_4 = 7'b001_1001;
    localparam logic [6:0] SEG_5 = 7'b001_0010;
    localparam logic [6:0] SEG_6 = 7'b000_0010;
    localparam logic [6:0] SEG_7 = 7'b111_1000;
    localparam logic [6:0] SEG_8 = 7'b000_0000;
    localparam logic [6:0] SEG_9 = 7'b001_0000;
    localparam logic [6:0] SEG_A = 7'b000_1000;
    localparam logic [6:0] SEG_B = 7'b000_0011;
    localparam logic [6:0] SEG_C = 7'b100_0110;
    localparam logic [6:0] SEG_D = 7'b010_0001;
    localparam logic [6:0] SEG_E = 7'b000_0110;
    localparam logic [6:0] SEG_F = 7'b000_1110;
    localparam logic [6:0] SEG_OFF = 7'b111_1111;

endpackage

// File: rtl/key_debounce.sv
// Raw active-low push button -> synchronizer -> debouncer -> one-cycle press
// pulse on a debounced 1->0 transition; releases produce nothing.
module key_debounce #(
    parameter int DEBOUNCE = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic          sync_a;
    logic          sync_b;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    // Everything resets to "released" so a reset never fabricates a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a   <= 1'b1;
            sync_b   <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values; the sync chain depends on it.
            sync_a   <= key_n;
            sync_b   <= sync_a;
            stable_d <= stable;
            press    <= stable_d & ~stable;
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_b;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dec_entry.sv
// Decimal number entry: debounced add/clear keys append BCD digits into a
// binary accumulator (value*10 + digit) with full, overflow and bad-digit flags.
module dec_entry
    import num_syst_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3,
    parameter int DEBOUNCE   = 50000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              add_key_n,
    input  logic                              clr_key_n,
    input  logic [3:0]                        digit,
    output logic [WIDTH-1:0]                  value,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_cnt,
    output logic                              full,
    output logic                              overflow,
    output logic                              bad_digit
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

    localparam logic [1:0] ST_EMPTY = EMPTY;
    localparam logic [1:0] ST_ENTRY = ENTRY;
    localparam logic [1:0] ST_FULL  = FULL;
    localparam logic [1:0] ST_OVF   = OVF;

    logic             add_press;
    logic             clr_press;
    logic [1:0]       state;
    logic [WIDTH+3:0] v_ext;
    logic [WIDTH+3:0] next_val;
    logic             fits;
    logic [CW-1:0]    cnt_inc;
    logic             accepting;

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_add_key (
        .clk   (clk),
        .reset (reset),
        .key_n (add_key_n),
        .press (add_press)
    );

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_clr_key (
        .clk   (clk),
        .reset (reset),
        .key_n (clr_key_n),
        .press (clr_press)
    );

    // x10 as shift-and-add, four guard bits so the overflow test sees the carry.
    always_comb begin
        v_ext     = {4'b0000, value};
        next_val  = (v_ext << 3) + (v_ext << 1) + {{WIDTH{1'b0}}, digit};
        fits      = (next_val[WIDTH+3:WIDTH] == 4'd0);
        cnt_inc   = digit_cnt + 1'b1;
        accepting = (state == ST_EMPTY) || (state == ST_ENTRY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_EMPTY;
            value     <= '0;
            digit_cnt <= '0;
            bad_digit <= 1'b0;
        end else if (clr_press) begin
            state     <= ST_EMPTY;
            value     <= '0;
            digit_cnt <= '0;
            bad_digit <= 1'b0;
        end else if (add_press && accepting) begin
            if (digit > BCD_MAX) begin
                bad_digit <= 1'b1;
            end else if (!fits) begin
                state <= ST_OVF;
            end else begin
                value     <= next_val[WIDTH-1:0];
                digit_cnt <= cnt_inc;
                bad_digit <= 1'b0;
                state     <= (cnt_inc == MAX_CNT) ? ST_FULL : ST_ENTRY;
            end
        end
    end

    assign full     = (state == ST_FULL);
    assign overflow = (state == ST_OVF);

endmodule
